spi_frame_tx: RTL

SPI responder (slave-side transmitter) that drives a 40-bit frame onto MISO, MSB first, one bit per clk while the controller holds SS low. It sits at the sensor/remote end of the link and feeds the controller-side 40-bit frame receiver. Frames are loaded through a valid/ready handshake into a one-deep holding register. If no new frame is pending when SS falls, the last frame is repeated.

---
 rtl/spi_frame_tx.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_frame_tx.sv
// -----------------------------------------------------------------------------
// spi_frame_tx
// SPI responder-side frame transmitter. Shifts a FRAME_BITS-wide frame onto
// MISO, MSB first, one bit per clk while the controller holds SS low. Frames
// arrive through a valid/ready handshake into a one-deep holding register. If
// no new frame is pending when SS falls, the previous frame is sent again and
// UNDERRUN pulses.
//
// Optional build macro:
//   SPI_FRAME_TX_SS_SYNC_EN - pass SS through a 2-flop synchronizer (reset
//                             high) before edge detection. Every SS-related
//                             event then occurs two cycles later.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   SS         in   slave select, active low
//   DIN        in   frame to transmit (FRAME_BITS)
//   DIN_VALID  in   DIN valid
//   DIN_READY  out  holding register empty
//   MISO       out  serial data, IDLE_LEVEL outside SHIFT
//   BUSY       out  high while shifting a frame
//   FRAME_DONE out  1-cycle pulse after the last bit of a frame
//   UNDERRUN   out  1-cycle pulse when a frame starts with no new data
//   ABORT      out  1-cycle pulse when SS rises mid-frame
// -----------------------------------------------------------------------------
module spi_frame_tx #(
    parameter int   FRAME_BITS = 40,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  SS,
    input  logic [FRAME_BITS-1:0] DIN,
    input  logic                  DIN_VALID,
    output logic                  DIN_READY,
    output logic                  MISO,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic                  UNDERRUN,
    output logic                  ABORT
);

    localparam int CNT_W = $clog2(FRAME_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                  state_q,     state_d;
    logic [FRAME_BITS-1:0]   shift_q,     shift_d;
    logic [FRAME_BITS-1:0]   last_q,      last_d;
    logic [FRAME_BITS-1:0]   hold_q,      hold_d;
    logic                    hold_full_q, hold_full_d;
    logic [CNT_W-1:0]        cnt_q,       cnt_d;
    logic                    done_q,      done_d;
    logic                    underrun_q,  underrun_d;
    logic                    abort_q,     abort_d;
    logic                    ss_q;
    logic                    armed_q;

    logic ss_s;
    logic fall_s;
    logic start_s;
    logic consume_s;
    logic accept_s;

`ifdef SPI_FRAME_TX_SS_SYNC_EN
    logic ss_meta_q;
    logic ss_sync_q;

    // Two-flop synchronizer for an SS coming from another clock domain or a pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_meta_q <= 1'b1;
            ss_sync_q <= 1'b1;
        end else begin
            ss_meta_q <= SS;
            ss_sync_q <= ss_meta_q;
        end
    end

    assign ss_s = ss_sync_q;
`else
    assign ss_s = SS;
`endif

    // ss_q resets high, so on its own a SS held low through reset would look
    // like a fresh falling edge. armed_q only lets an edge count once SS has
    // been seen high since reset.
    assign fall_s    = armed_q && ss_q && !ss_s;
    assign start_s   = (state_q == ST_IDLE) && fall_s;
    assign consume_s = start_s && hold_full_q;
    // The holding register frees up in the consume cycle, so a word offered in
    // that same cycle is taken even though DIN_READY is still low.
    assign accept_s  = DIN_VALID && (!hold_full_q || consume_s);

    // Next-state logic for the frame FSM, holding register and pulse outputs.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        last_d      = last_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        underrun_d  = 1'b0;
        abort_d     = 1'b0;

        if (accept_s) begin
            hold_d      = DIN;
            hold_full_d = 1'b1;
        end else if (consume_s) begin
            hold_full_d = 1'b0;
        end else begin
            hold_full_d = hold_full_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_s) begin
                    shift_d    = hold_full_q ? hold_q : last_q;
                    last_d     = hold_full_q ? hold_q : last_q;
                    cnt_d      = '0;
                    underrun_d = !hold_full_q;
                    state_d    = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (ss_s) begin
                    // Controller deselected mid-frame: drop the partial frame.
                    state_d = ST_IDLE;
                    abort_d = 1'b1;
                end else begin
                    shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
                    cnt_d   = cnt_q + CNT_W'(1'b1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = ST_WAIT;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_WAIT: begin
                // No re-trigger until SS has been released.
                if (ss_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, data and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            last_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
            abort_q     <= 1'b0;
            ss_q        <= 1'b1;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            last_q      <= last_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
            abort_q     <= abort_d;
            ss_q        <= ss_s;
            armed_q     <= armed_q | ss_s;
        end
    end

    assign DIN_READY  = !hold_full_q;
    assign BUSY       = (state_q == ST_SHIFT);
    assign MISO       = (state_q == ST_SHIFT) ? shift_q[FRAME_BITS-1] : IDLE_LEVEL;
    assign FRAME_DONE = done_q;
    assign UNDERRUN   = underrun_q;
    assign ABORT      = abort_q;

endmodule
